wb_arbiter_2m: RTL and testbench

- Two-master Wishbone arbiter in front of `wb_interconnect`.
- Shares the single CPU-side bus between instruction-fetch (M0) and load/store (M1) masters.
- Round-robin on contention; a grant is held for a master's whole CYC.
- A per-transfer watchdog terminates stalled slaves with an error to the granted master.

---
 rtl/wb_arbiter_2m_if.sv | 43 ++++
 rtl/wb_arbiter_2m.sv | 116 +++++++++++
 tb/tb_wb_arbiter_2m.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_2m_if.sv
// Bus bundle for the two-master Wishbone arbiter: both master-side ports and the
// single interconnect-side port. 'slave' is the arbiter's view, 'master' the environment's.
interface wb_arbiter_2m_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] M0_ADR_O, M1_ADR_O;
  logic [DATA_WIDTH-1:0] M0_DAT_O, M1_DAT_O;
  logic                  M0_WE_O,  M1_WE_O;
  logic [SEL_WIDTH-1:0]  M0_SEL_O, M1_SEL_O;
  logic                  M0_STB_O, M1_STB_O;
  logic                  M0_CYC_O, M1_CYC_O;
  logic [DATA_WIDTH-1:0] M0_DAT_I, M1_DAT_I;
  logic                  M0_ACK_I, M1_ACK_I;
  logic                  M0_ERR_I, M1_ERR_I;

  logic [ADDR_WIDTH-1:0] S_ADR_I;
  logic [DATA_WIDTH-1:0] S_DAT_I;
  logic                  S_WE_I;
  logic [SEL_WIDTH-1:0]  S_SEL_I;
  logic                  S_STB_I;
  logic                  S_CYC_I;
  logic [DATA_WIDTH-1:0] S_DAT_O;
  logic                  S_ACK_O;

  modport slave (
    input  M0_ADR_O, M1_ADR_O, M0_DAT_O, M1_DAT_O, M0_WE_O, M1_WE_O,
    input  M0_SEL_O, M1_SEL_O, M0_STB_O, M1_STB_O, M0_CYC_O, M1_CYC_O,
    output M0_DAT_I, M1_DAT_I, M0_ACK_I, M1_ACK_I, M0_ERR_I, M1_ERR_I,
    output S_ADR_I, S_DAT_I, S_WE_I, S_SEL_I, S_STB_I, S_CYC_I,
    input  S_DAT_O, S_ACK_O
  );

  modport master (
    output M0_ADR_O, M1_ADR_O, M0_DAT_O, M1_DAT_O, M0_WE_O, M1_WE_O,
    output M0_SEL_O, M1_SEL_O, M0_STB_O, M1_STB_O, M0_CYC_O, M1_CYC_O,
    input  M0_DAT_I, M1_DAT_I, M0_ACK_I, M1_ACK_I, M0_ERR_I, M1_ERR_I,
    input  S_ADR_I, S_DAT_I, S_WE_I, S_SEL_I, S_STB_I, S_CYC_I,
    output S_DAT_O, S_ACK_O
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin on contention, grant held for the whole
// CYC, with a per-transfer watchdog that terminates stalled slaves with ERR.
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_arbiter_2m_if.slave  bus,
  output logic [1:0]      gnt_o
);
  localparam int  SEL_WIDTH = DATA_WIDTH / 8;
  localparam int  TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit  WD_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_t;

  state_t        state_q, state_d;
  master_t       last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;

  logic                  req0, req1, sel1, timeout;
  logic [ADDR_WIDTH-1:0] m_adr;
  logic [DATA_WIDTH-1:0] m_dat;
  logic [SEL_WIDTH-1:0]  m_sel;
  logic                  m_we, m_stb, m_cyc;

  assign req0 = bus.M0_CYC_O & bus.M0_STB_O;
  assign req1 = bus.M1_CYC_O & bus.M1_STB_O;
  assign sel1 = (state_q == GNT1);

  assign m_adr = sel1 ? bus.M1_ADR_O : bus.M0_ADR_O;
  assign m_dat = sel1 ? bus.M1_DAT_O : bus.M0_DAT_O;
  assign m_sel = sel1 ? bus.M1_SEL_O : bus.M0_SEL_O;
  assign m_we  = sel1 ? bus.M1_WE_O  : bus.M0_WE_O;
  assign m_stb = sel1 ? bus.M1_STB_O : bus.M0_STB_O;
  assign m_cyc = sel1 ? bus.M1_CYC_O : bus.M0_CYC_O;

  // An ACK arriving on the timeout cycle wins, so ERR and ACK never coincide.
  assign timeout = WD_EN && (timer_q == TMAX) && !bus.S_ACK_O;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d      = state_q;
    last_d       = last_q;
    timer_d      = timer_q;
    gnt_o        = 2'b00;
    bus.S_ADR_I  = '0;
    bus.S_DAT_I  = '0;
    bus.S_WE_I   = 1'b0;
    bus.S_SEL_I  = '0;
    bus.S_STB_I  = 1'b0;
    bus.S_CYC_I  = 1'b0;
    bus.M0_DAT_I = '0;
    bus.M1_DAT_I = '0;
    bus.M0_ACK_I = 1'b0;
    bus.M1_ACK_I = 1'b0;
    bus.M0_ERR_I = 1'b0;
    bus.M1_ERR_I = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (req0 && (!req1 || last_q == M1)) begin
          state_d = GNT0;
          last_d  = M0;
        end else if (req1) begin
          state_d = GNT1;
          last_d  = M1;
        end
      end
      GNT0, GNT1: begin
        gnt_o       = sel1 ? 2'b10 : 2'b01;
        bus.S_ADR_I = m_adr;
        bus.S_DAT_I = m_dat;
        bus.S_WE_I  = m_we;
        bus.S_SEL_I = m_sel;
        bus.S_STB_I = m_stb & ~timeout;
        bus.S_CYC_I = m_cyc & ~timeout;
        if (sel1) begin
          bus.M1_DAT_I = bus.S_DAT_O;
          bus.M1_ACK_I = bus.S_ACK_O;
          bus.M1_ERR_I = timeout;
        end else begin
          bus.M0_DAT_I = bus.S_DAT_O;
          bus.M0_ACK_I = bus.S_ACK_O;
          bus.M0_ERR_I = timeout;
        end
        if (bus.S_ACK_O)
          timer_d = '0;
        else if (m_stb && timer_q != TMAX)
          timer_d = timer_q + TW'(1);
        if (timeout || !m_cyc)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: last_q resets to M1 so M0 wins the first contention after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= M1;
      timer_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all update together at the edge.
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios plus a randomized
// two-master run against a transaction-level arbitration model.
module tb_wb_arbiter_2m;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] gnt;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .gnt_o (gnt)
  );

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    if (m == 0) begin
      bus.M0_CYC_O = cyc; bus.M0_STB_O = stb; bus.M0_WE_O = we;
      bus.M0_ADR_O = adr; bus.M0_DAT_O = dat; bus.M0_SEL_O = sel;
    end else begin
      bus.M1_CYC_O = cyc; bus.M1_STB_O = stb; bus.M1_WE_O = we;
      bus.M1_ADR_O = adr; bus.M1_DAT_O = dat; bus.M1_SEL_O = sel;
    end
  endtask

  task automatic idle_inputs;
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus.S_ACK_O = 1'b0;
    bus.S_DAT_O = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? bus.M0_ACK_I : bus.M1_ACK_I;
  endfunction

  function automatic logic err_of(input int m);
    return (m == 0) ? bus.M0_ERR_I : bus.M1_ERR_I;
  endfunction

  function automatic logic [DW-1:0] dat_of(input int m);
    return (m == 0) ? bus.M0_DAT_I : bus.M1_DAT_I;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h1000, '0, 4'hF);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h2000, '0, 4'hF);
    bus.S_ACK_O = 1'b1;
    @(posedge clk); #1;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rst_gnt: got %b want 00", gnt); end
    checks++; if (bus.S_CYC_I !== 1'b0 || bus.S_STB_I !== 1'b0) begin failures++; $display("FAIL rst_bus: cyc=%b stb=%b want 0", bus.S_CYC_I, bus.S_STB_I); end
    checks++; if ({bus.M0_ACK_I, bus.M1_ACK_I, bus.M0_ERR_I, bus.M1_ERR_I} !== 4'b0) begin failures++; $display("FAIL rst_ackerr: got %b want 0000", {bus.M0_ACK_I, bus.M1_ACK_I, bus.M0_ERR_I, bus.M1_ERR_I}); end
    do_reset();
  endtask

  task automatic test_single_read;
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0010, '0, 4'hF);
    settle();
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rd_latency: got %b want 00", gnt); end
    tick(); settle();
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rd_gnt: got %b want 01", gnt); end
    checks++; if (bus.S_ADR_I !== 32'h3000_0010 || bus.S_CYC_I !== 1'b1 || bus.S_WE_I !== 1'b0) begin failures++; $display("FAIL rd_route: adr=%h cyc=%b we=%b want 30000010/1/0", bus.S_ADR_I, bus.S_CYC_I, bus.S_WE_I); end
    checks++; if (bus.M0_ACK_I !== 1'b0) begin failures++; $display("FAIL rd_noack: got %b want 0", bus.M0_ACK_I); end
    tick();
    bus.S_ACK_O = 1'b1; bus.S_DAT_O = 32'hDEAD_BEEF;
    settle();
    checks++; if (bus.M0_ACK_I !== 1'b1 || bus.M0_DAT_I !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data: ack=%b dat=%h want 1/deadbeef", bus.M0_ACK_I, bus.M0_DAT_I); end
    checks++; if (bus.M0_ERR_I !== 1'b0 || bus.M1_DAT_I !== '0) begin failures++; $display("FAIL rd_other: err=%b m1dat=%h want 0/0", bus.M0_ERR_I, bus.M1_DAT_I); end
    tick();
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus.S_ACK_O = 1'b0;
    settle();
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rd_hold: got %b want 01", gnt); end
    tick(); settle();
    checks++; if (gnt !== 2'b00 || bus.S_CYC_I !== 1'b0) begin failures++; $display("FAIL rd_idle: gnt=%b cyc=%b want 00/0", gnt, bus.S_CYC_I); end
  endtask

  task automatic test_contention;
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'hA000, '0, 4'hF);
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'hB000, 32'h1234, 4'h3);
    settle();
    tick(); settle();
    checks++; if (gnt !== 2'b01 || bus.S_ADR_I !== 32'hA000) begin failures++; $display("FAIL ct_first: gnt=%b adr=%h want 01/a000", gnt, bus.S_ADR_I); end
    tick();
    bus.S_ACK_O = 1'b1;
    settle();
    checks++; if (bus.M0_ACK_I !== 1'b1 || bus.M1_ACK_I !== 1'b0) begin failures++; $display("FAIL ct_ack0: m0=%b m1=%b want 1/0", bus.M0_ACK_I, bus.M1_ACK_I); end
    tick();
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus.S_ACK_O = 1'b0;
    settle();
    checks++; if (gnt !== 2'b01 || bus.M1_ACK_I !== 1'b0) begin failures++; $display("FAIL ct_tail: gnt=%b m1ack=%b want 01/0", gnt, bus.M1_ACK_I); end
    tick(); settle();
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL ct_gap: got %b want 00", gnt); end
    tick(); settle();
    checks++; if (gnt !== 2'b10 || bus.S_ADR_I !== 32'hB000 || bus.S_WE_I !== 1'b1 || bus.S_SEL_I !== 4'h3) begin failures++; $display("FAIL ct_second: gnt=%b adr=%h we=%b sel=%h", gnt, bus.S_ADR_I, bus.S_WE_I, bus.S_SEL_I); end
    bus.S_ACK_O = 1'b1;
    settle();
    checks++; if (bus.M1_ACK_I !== 1'b1 || bus.M0_ACK_I !== 1'b0) begin failures++; $display("FAIL ct_ack1: m1=%b m0=%b want 1/0", bus.M1_ACK_I, bus.M0_ACK_I); end
    tick();
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_back_to_back;
    int   served [2];
    logic ack_prev [2];
    logic [1:0] prev_gnt;
    int   n_grants;
    logic [1:0] want;
    do_reset();
    served = '{0, 0};
    ack_prev = '{1'b0, 1'b0};
    prev_gnt = 2'b00;
    n_grants = 0;
    for (int c = 0; c < 200; c++) begin
      for (int m = 0; m < 2; m++) begin
        logic r;
        r = (served[m] < 4) && !ack_prev[m];
        drive_m(m, r, r, 1'b1, AW'(m * 16 + served[m]), DW'(c), 4'hF);
      end
      #1;
      bus.S_ACK_O = bus.S_STB_I;
      #1;
      if (gnt !== 2'b00 && prev_gnt === 2'b00) begin
        want = (n_grants % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (gnt !== want) begin failures++; $display("FAIL b2b_order%0d: got %b want %b", n_grants, gnt, want); end
        n_grants++;
      end
      if (gnt !== 2'b00 && prev_gnt !== 2'b00 && gnt !== prev_gnt) begin
        checks++; failures++;
        $display("FAIL b2b_gap: grant moved %b->%b without IDLE", prev_gnt, gnt);
      end
      for (int m = 0; m < 2; m++) begin
        ack_prev[m] = ack_of(m);
        if (ack_of(m) === 1'b1) served[m]++;
      end
      prev_gnt = gnt;
      if (served[0] >= 4 && served[1] >= 4 && gnt === 2'b00) break;
      @(posedge clk); #1;
    end
    checks++; if (n_grants != 8 || served[0] != 4 || served[1] != 4) begin failures++; $display("FAIL b2b_count: grants=%0d s0=%0d s1=%0d want 8/4/4", n_grants, served[0], served[1]); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_burst;
    do_reset();
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'hC000, '0, 4'hF);
    settle();
    tick(); settle();
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL bu_gnt: got %b want 10", gnt); end
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'hD000, '0, 4'hF);
    for (int b = 0; b < 3; b++) begin
      bus.S_ACK_O = 1'b0;
      settle();
      checks++; if (gnt !== 2'b10 || bus.M0_ACK_I !== 1'b0) begin failures++; $display("FAIL bu_wait%0d: gnt=%b m0ack=%b want 10/0", b, gnt, bus.M0_ACK_I); end
      tick();
      bus.S_ACK_O = 1'b1;
      bus.S_DAT_O = 32'h5000_0000 + DW'(b);
      settle();
      checks++; if (gnt !== 2'b10 || bus.M1_ACK_I !== 1'b1 || bus.M0_ACK_I !== 1'b0 || bus.M1_DAT_I !== 32'h5000_0000 + DW'(b)) begin failures++; $display("FAIL bu_beat%0d: gnt=%b m1ack=%b m0ack=%b dat=%h", b, gnt, bus.M1_ACK_I, bus.M0_ACK_I, bus.M1_DAT_I); end
      tick();
      drive_m(1, 1'b1, 1'b1, 1'b0, 32'hC000 + AW'(4 * (b + 1)), '0, 4'hF);
    end
    bus.S_ACK_O = 1'b0;
    drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL bu_tail: got %b want 10", gnt); end
    tick(); settle();
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL bu_gap: got %b want 00", gnt); end
    tick(); settle();
    checks++; if (gnt !== 2'b01 || bus.S_ADR_I !== 32'hD000) begin failures++; $display("FAIL bu_m0: gnt=%b adr=%h want 01/d000", gnt, bus.S_ADR_I); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_watchdog;
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'hE000, 32'hCAFE, 4'hF);
    settle();
    tick();
    for (int w = 1; w <= TO; w++) begin
      settle();
      checks++; if (bus.M0_ERR_I !== 1'b0 || bus.S_CYC_I !== 1'b1 || gnt !== 2'b01) begin failures++; $display("FAIL wd_wait%0d: err=%b cyc=%b gnt=%b want 0/1/01", w, bus.M0_ERR_I, bus.S_CYC_I, gnt); end
      tick();
    end
    settle();
    checks++; if (bus.M0_ERR_I !== 1'b1 || bus.M0_ACK_I !== 1'b0) begin failures++; $display("FAIL wd_err: err=%b ack=%b want 1/0", bus.M0_ERR_I, bus.M0_ACK_I); end
    checks++; if (bus.S_CYC_I !== 1'b0 || bus.S_STB_I !== 1'b0) begin failures++; $display("FAIL wd_drop: cyc=%b stb=%b want 0/0", bus.S_CYC_I, bus.S_STB_I); end
    tick(); settle();
    checks++; if (gnt !== 2'b00 || bus.M0_ERR_I !== 1'b0) begin failures++; $display("FAIL wd_idle: gnt=%b err=%b want 00/0", gnt, bus.M0_ERR_I); end
    tick();
    for (int w = 1; w <= TO; w++) begin
      settle();
      checks++; if (gnt !== 2'b01 || bus.M0_ERR_I !== 1'b0) begin failures++; $display("FAIL wd_rearb%0d: gnt=%b err=%b want 01/0", w, gnt, bus.M0_ERR_I); end
      tick();
    end
    bus.S_ACK_O = 1'b1;
    settle();
    checks++; if (bus.M0_ACK_I !== 1'b1 || bus.M0_ERR_I !== 1'b0 || bus.S_CYC_I !== 1'b1) begin failures++; $display("FAIL wd_ackwins: ack=%b err=%b cyc=%b want 1/0/1", bus.M0_ACK_I, bus.M0_ERR_I, bus.S_CYC_I); end
    tick();
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'hF000, '0, 4'hF);
    settle();
    tick();
    bus.S_ACK_O = 1'b1;
    settle();
    checks++; if (bus.M0_ACK_I !== 1'b1 || bus.S_CYC_I !== 1'b1) begin failures++; $display("FAIL ar_pre: ack=%b cyc=%b want 1/1", bus.M0_ACK_I, bus.S_CYC_I); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.S_CYC_I !== 1'b0 || bus.S_STB_I !== 1'b0 || gnt !== 2'b00) begin failures++; $display("FAIL ar_drop: cyc=%b stb=%b gnt=%b want 0/0/00", bus.S_CYC_I, bus.S_STB_I, gnt); end
    checks++; if (bus.M0_ACK_I !== 1'b0 || bus.M0_ERR_I !== 1'b0) begin failures++; $display("FAIL ar_ack: ack=%b err=%b want 0/0", bus.M0_ACK_I, bus.M0_ERR_I); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h10, '0, 4'hF);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h20, '0, 4'hF);
    settle();
    tick(); settle();
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL ar_first: got %b want 01", gnt); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_random;
    int owner, last, slave_wait, old_owner;
    logic act [2];
    int   gap [2];
    int   beats [2];
    logic we [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] dat [2];
    logic [SW-1:0] sel [2];
    logic s_ack, exp_stb;
    logic [DW-1:0] s_dat;
    logic [1:0] exp_gnt;
    do_reset();
    owner = -1; last = 1; slave_wait = 0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; gap[m] = $urandom_range(0, 2); beats[m] = 0;
      we[m] = 1'b0; adr[m] = '0; dat[m] = '0; sel[m] = '0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int m = 0; m < 2; m++) drive_m(m, act[m], act[m], we[m], adr[m], dat[m], sel[m]);
      exp_stb = (owner >= 0) && act[owner];
      s_ack = exp_stb && (slave_wait >= 2 || $urandom_range(0, 2) == 0);
      s_dat = $urandom;
      bus.S_ACK_O = s_ack;
      bus.S_DAT_O = s_dat;
      settle();
      exp_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, exp_gnt); end
      checks++; if (bus.M0_ERR_I !== 1'b0 || bus.M1_ERR_I !== 1'b0) begin failures++; $display("FAIL rnd_err c%0d: %b%b want 00", c, bus.M0_ERR_I, bus.M1_ERR_I); end
      if (owner >= 0) begin
        checks++; if (bus.S_ADR_I !== adr[owner] || bus.S_DAT_I !== dat[owner] || bus.S_WE_I !== we[owner] || bus.S_SEL_I !== sel[owner] || bus.S_CYC_I !== act[owner] || bus.S_STB_I !== act[owner]) begin failures++; $display("FAIL rnd_route c%0d: adr=%h want %h", c, bus.S_ADR_I, adr[owner]); end
        checks++; if (ack_of(owner) !== s_ack || (s_ack && dat_of(owner) !== s_dat)) begin failures++; $display("FAIL rnd_resp c%0d: ack=%b dat=%h want %b/%h", c, ack_of(owner), dat_of(owner), s_ack, s_dat); end
        checks++; if (ack_of(1 - owner) !== 1'b0 || dat_of(1 - owner) !== '0 || err_of(1 - owner) !== 1'b0) begin failures++; $display("FAIL rnd_other c%0d: ack=%b dat=%h want 0/0", c, ack_of(1 - owner), dat_of(1 - owner)); end
      end else begin
        checks++; if (bus.S_CYC_I !== 1'b0 || bus.S_STB_I !== 1'b0 || bus.M0_ACK_I !== 1'b0 || bus.M1_ACK_I !== 1'b0) begin failures++; $display("FAIL rnd_idle c%0d: cyc=%b stb=%b acks=%b%b want 0", c, bus.S_CYC_I, bus.S_STB_I, bus.M0_ACK_I, bus.M1_ACK_I); end
      end
      // Arbitration rules: idle bus goes to the sole requester, or on contention
      // to whoever was not served last; a grant ends when its master drops CYC.
      old_owner = owner;
      if (owner < 0) begin
        if (act[0] && act[1]) owner = 1 - last;
        else if (act[0])      owner = 0;
        else if (act[1])      owner = 1;
        if (owner >= 0) last = owner;
        slave_wait = 0;
      end else begin
        if (s_ack) slave_wait = 0;
        else if (exp_stb) slave_wait++;
        if (!act[owner]) owner = -1;
      end
      for (int m = 0; m < 2; m++) begin
        if (act[m]) begin
          if (m == old_owner && s_ack) begin
            beats[m]--;
            if (beats[m] == 0) begin
              act[m] = 1'b0;
              gap[m] = $urandom_range(0, 2);
            end else begin
              adr[m] = $urandom; dat[m] = $urandom;
            end
          end
        end else if (gap[m] == 0) begin
          act[m] = 1'b1; beats[m] = $urandom_range(1, 3);
          we[m] = 1'($urandom_range(0, 1)); adr[m] = $urandom; dat[m] = $urandom;
          sel[m] = SW'($urandom_range(1, 15));
        end else begin
          gap[m]--;
        end
      end
      tick();
    end
    idle_inputs();
    tick(); tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_burst();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
